fifo_sync_prog: RTL and testbench
=================================

Name: fifo_sync_prog

Overview:
- Parametrised synchronous FIFO; next generation of the team's 16-entry buffer.
- Generalised in data width and depth.
- Adds runtime-programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a defined simultaneous read/write policy at the full and empty boundaries.
- Sits between the producer and consumer blocks of the datapath. Single clock domain.

Parameters:
- DATA_WIDTH, 4, bits per entry.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 16).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- wr_en  in  1  write request.
- buf_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- buf_out  out  DATA_WIDTH  read data (registered).
- af_thresh  in  ADDR_WIDTH+1  almost-full margin.
- ae_thresh  in  ADDR_WIDTH+1  almost-empty level.
- err_clr  in  1  synchronous clear of error flags.
- buf_full  out  1  count == DEPTH.
- buf_empty  out  1  count == 0.
- almost_full  out  1  count >= DEPTH - af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- overflow  out  1  sticky: write attempted while full and not accepted.
- underflow  out  1  sticky: read attempted while empty.
- fifo_counter  out  ADDR_WIDTH+1  current occupancy.

Behaviour:
- Reset (rst=0, async): wr/rd pointers=0, fifo_counter=0, buf_out=0, buf_empty=1, buf_full=0, overflow=0, underflow=0. almost_empty/almost_full then follow the thresholds combinationally. Memory contents are not reset.
- Write accepted: wr_en && (!buf_full || rd_accepted). Memory[wr_ptr] <= buf_in; wr_ptr increments modulo DEPTH (natural wrap).
- Read accepted: rd_en && !buf_empty. buf_out <= memory[rd_ptr] at that edge, so data is valid 1 cycle after the rd_en edge. rd_ptr increments modulo DEPTH. buf_out holds its value when no read occurs.
- Count update:
  - write only: +1.
  - read only: -1.
  - both, or neither: unchanged.
- Full + wr_en + rd_en: both performed, count stays DEPTH, no overflow.
- Empty + wr_en + rd_en: write only, count becomes 1, underflow set, buf_out unchanged.
- Full + wr_en alone: write dropped, overflow set at that edge.
- Empty + rd_en alone: underflow set.
- Error flags: sticky until err_clr=1 at a clock edge. If err_clr and a new error occur in the same cycle, the flag stays set.
- Flags are combinational from the registered count: buf_full, buf_empty, almost_*.
- Threshold arithmetic is done at ADDR_WIDTH+1 bits. af_thresh > DEPTH saturates, so almost_full=1 always.
- Reset asserted mid-operation: immediate return to the reset state; in-flight accesses are discarded.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - buf_out continuously presents memory[rd_ptr] whenever !buf_empty; rd_en acknowledges and pops.
  - Read latency is 0: the word written into an empty FIFO appears on buf_out one cycle after the write edge.
  - buf_out = 0 while empty.
- Undefined: standard registered-read behaviour as specified above.

Decomposition:
- Shared header fifo_defs.vh holds:
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - the FIFO_FWFT_EN guard documentation;
  - the localparam expression for DEPTH, reused by future FIFO variants.
- One sub-module, fifo_mem: a DEPTH x DATA_WIDTH dual-port register array with synchronous write, read address input and combinational read.
- The top level owns pointers, counter, flags and the buf_out register.

Test Plan (DATA_WIDTH=4, ADDR_WIDTH=4, af_thresh=2, ae_thresh=2):
- Reset: hold rst=0 for 15 ns, then release -> buf_empty=1, fifo_counter=0, almost_empty=1, buf_out=0, error flags=0.
- Ordering: push 1,2,3, then pop 3 times -> buf_out reads 1,2,3 on successive cycles after each rd edge; count returns to 0; almost_empty asserted at count<=2.
- Fill: push values 0..15 -> almost_full asserted from count 14, buf_full at 16. Then a 17th push -> data dropped, overflow=1, count stays 16. err_clr pulse -> overflow=0.
- Full + simultaneous rd/wr of 9 -> buf_out=0 (oldest), count stays 16, no overflow. Draining all 16 entries returns 1..15 then 9 (wrap-around verified).
- Empty + simultaneous rd/wr of 5 -> underflow=1, count=1. Next pop returns 5 -> buf_empty=1.
- Async reset mid-stream: assert rst=0 between edges with count=7 -> count=0 and flags at reset values immediately, without waiting for clk. With FIFO_FWFT_EN: a single push of 6 into empty -> buf_out=6 on the next cycle without rd_en.

Source files
------------

// File: rtl/fifo_sync_prog_pkg.sv
// Shared FIFO definitions: default geometry, DEPTH derivation reused by future FIFO variants.
// FIFO_FWFT_EN (when defined) switches the FIFO top to first-word-fall-through read data.
package fifo_sync_prog_pkg;

    localparam int FIFO_DATA_WIDTH_DEF = 4;
    localparam int FIFO_ADDR_WIDTH_DEF = 4;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Encoded as {write_accepted, read_accepted}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_sync_prog_if.sv
// Producer/consumer-facing bundle of the programmable FIFO; master drives requests, slave is the FIFO.
interface fifo_sync_prog_if
    import fifo_sync_prog_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] buf_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] buf_out;
    logic [ADDR_WIDTH:0]   af_thresh;
    logic [ADDR_WIDTH:0]   ae_thresh;
    logic                  err_clr;
    logic                  buf_full;
    logic                  buf_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
    logic [ADDR_WIDTH:0]   fifo_counter;

    modport master (
        output wr_en, buf_in, rd_en, af_thresh, ae_thresh, err_clr,
        input  buf_out, buf_full, buf_empty, almost_full, almost_empty,
               overflow, underflow, fifo_counter
    );

    modport slave (
        input  wr_en, buf_in, rd_en, af_thresh, ae_thresh, err_clr,
        output buf_out, buf_full, buf_empty, almost_full, almost_empty,
               overflow, underflow, fifo_counter
    );
endinterface

// File: rtl/fifo_sync_prog_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH register array, synchronous write, combinational read.
module fifo_mem
    import fifo_sync_prog_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with programmable almost-full/empty thresholds and sticky error flags.
// Build with FIFO_FWFT_EN defined for first-word-fall-through read data.
module fifo_sync_prog
    import fifo_sync_prog_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
) (
    input logic             clk,
    input logic             rst,
    fifo_sync_prog_if.slave bus
);
    localparam int                DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  overflow_q;
    logic                  underflow_q;
    fifo_op_e              op;

    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    assign rd_acc = bus.rd_en && !empty;
    // A full FIFO still takes a write when the same edge frees a slot
    assign wr_acc = bus.wr_en && (!full || rd_acc);
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.buf_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case (op)
                OP_WR:   count <= count + 1'b1;
                OP_RD:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A fresh error wins over a same-cycle clear
            overflow_q  <= (overflow_q  && !bus.err_clr) || (bus.wr_en && !wr_acc);
            underflow_q <= (underflow_q && !bus.err_clr) || (bus.rd_en && empty);
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.buf_out = empty ? '0 : rd_data;
`else
    logic [DATA_WIDTH-1:0] buf_out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_out_q <= '0;
        end else if (rd_acc) begin
            buf_out_q <= rd_data;
        end
    end

    assign bus.buf_out = buf_out_q;
`endif

    // Margins beyond DEPTH would wrap the subtraction, so they force almost_full
    assign bus.almost_full  = (bus.af_thresh >= DEPTH_C) || (count >= (DEPTH_C - bus.af_thresh));
    assign bus.almost_empty = (count <= bus.ae_thresh);
    assign bus.buf_full     = full;
    assign bus.buf_empty    = empty;
    assign bus.fifo_counter = count;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog: directed boundary scenarios plus randomized traffic vs a queue model.
module tb_fifo_sync_prog;
    localparam int DW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;

    fifo_sync_prog_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_sync_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_ovf  = 1'b0;
    bit            m_unf  = 1'b0;

    function automatic logic [DW-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
        return (q.size() != 0) ? q[0] : '0;
`else
        return m_dout;
`endif
    endfunction

    function automatic bit exp_af();
        return int'(q.size()) >= DEPTH - int'(bus.af_thresh);
    endfunction

    function automatic bit exp_ae();
        return int'(q.size()) <= int'(bus.ae_thresh);
    endfunction

    task automatic step(input bit wr, input logic [DW-1:0] din, input bit rd, input bit clr);
        int sz;
        bit rd_acc, wr_acc, new_o, new_u;
        bus.wr_en   = wr;
        bus.buf_in  = din;
        bus.rd_en   = rd;
        bus.err_clr = clr;
        @(posedge clk);
        sz     = q.size();
        rd_acc = rd && (sz != 0);
        wr_acc = wr && ((sz != DEPTH) || rd_acc);
        new_o  = wr && !wr_acc;
        new_u  = rd && (sz == 0);
        if (rd_acc) m_dout = q.pop_front();
        if (wr_acc) q.push_back(din);
        m_ovf = (m_ovf && !clr) || new_o;
        m_unf = (m_unf && !clr) || new_u;
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #15;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.buf_empty !== 1'b1) begin errors++; $display("FAIL rst_empty actual=%b expected=1", bus.buf_empty); end
        checks++; if (bus.buf_full !== 1'b0) begin errors++; $display("FAIL rst_full actual=%b expected=0", bus.buf_full); end
        checks++; if (bus.fifo_counter !== 5'd0) begin errors++; $display("FAIL rst_count actual=%0d expected=0", bus.fifo_counter); end
        checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL rst_ae actual=%b expected=1", bus.almost_empty); end
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL rst_af actual=%b expected=0", bus.almost_full); end
        checks++; if (bus.buf_out !== 4'd0) begin errors++; $display("FAIL rst_dout actual=%0d expected=0", bus.buf_out); end
        checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL rst_err actual=%b expected=00", {bus.overflow, bus.underflow}); end
    endtask

    task automatic test_ordering();
        for (int i = 1; i <= 3; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        checks++; if (bus.fifo_counter !== 5'd3) begin errors++; $display("FAIL ord_count3 actual=%0d expected=3", bus.fifo_counter); end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++; if (bus.buf_out !== exp_dout()) begin errors++; $display("FAIL ord_dout%0d actual=%0d expected=%0d", i, bus.buf_out, exp_dout()); end
            checks++; if (bus.almost_empty !== exp_ae()) begin errors++; $display("FAIL ord_ae%0d actual=%b expected=%b", i, bus.almost_empty, exp_ae()); end
        end
        checks++; if (bus.fifo_counter !== 5'd0) begin errors++; $display("FAIL ord_count0 actual=%0d expected=0", bus.fifo_counter); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 4'(i), 1'b0, 1'b0);
            checks++; if (bus.almost_full !== exp_af()) begin errors++; $display("FAIL fill_af cnt=%0d actual=%b expected=%b", q.size(), bus.almost_full, exp_af()); end
            checks++; if (bus.buf_full !== (q.size() == DEPTH)) begin errors++; $display("FAIL fill_full cnt=%0d actual=%b", q.size(), bus.buf_full); end
        end
        step(1'b1, 4'hA, 1'b0, 1'b0);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set actual=%b expected=1", bus.overflow); end
        checks++; if (bus.fifo_counter !== 5'd16) begin errors++; $display("FAIL ovf_count actual=%0d expected=16", bus.fifo_counter); end
        step(1'b0, '0, 1'b0, 1'b1);
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr actual=%b expected=0", bus.overflow); end
    endtask

    task automatic test_full_simul();
        logic [DW-1:0] want;
        step(1'b1, 4'd9, 1'b1, 1'b0);
        checks++; if (bus.buf_out !== exp_dout()) begin errors++; $display("FAIL fullrw_dout actual=%0d expected=%0d", bus.buf_out, exp_dout()); end
        checks++; if (bus.fifo_counter !== 5'd16) begin errors++; $display("FAIL fullrw_count actual=%0d expected=16", bus.fifo_counter); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fullrw_ovf actual=%b expected=0", bus.overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            want = (i < 15) ? 4'(i + 1) : 4'd9;
`ifdef FIFO_FWFT_EN
            checks++; if (bus.buf_out !== want) begin errors++; $display("FAIL drain%0d actual=%0d expected=%0d", i, bus.buf_out, want); end
            step(1'b0, '0, 1'b1, 1'b0);
`else
            step(1'b0, '0, 1'b1, 1'b0);
            checks++; if (bus.buf_out !== want) begin errors++; $display("FAIL drain%0d actual=%0d expected=%0d", i, bus.buf_out, want); end
`endif
        end
        checks++; if (bus.buf_empty !== 1'b1) begin errors++; $display("FAIL drain_empty actual=%b expected=1", bus.buf_empty); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL drain_unf actual=%b expected=0", bus.underflow); end
    endtask

    task automatic test_empty_simul();
        step(1'b1, 4'd5, 1'b1, 1'b0);
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL emptyrw_unf actual=%b expected=1", bus.underflow); end
        checks++; if (bus.fifo_counter !== 5'd1) begin errors++; $display("FAIL emptyrw_count actual=%0d expected=1", bus.fifo_counter); end
        checks++; if (bus.buf_out !== exp_dout()) begin errors++; $display("FAIL emptyrw_dout actual=%0d expected=%0d", bus.buf_out, exp_dout()); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.buf_out !== exp_dout()) begin errors++; $display("FAIL emptyrw_pop actual=%0d expected=%0d", bus.buf_out, exp_dout()); end
        checks++; if (bus.buf_empty !== 1'b1) begin errors++; $display("FAIL emptyrw_empty actual=%b expected=1", bus.buf_empty); end
        // Clear and new underflow on the same edge: flag must survive
        step(1'b0, '0, 1'b1, 1'b1);
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL clr_collide actual=%b expected=1", bus.underflow); end
        step(1'b0, '0, 1'b0, 1'b1);
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL unf_clr actual=%b expected=0", bus.underflow); end
    endtask

    task automatic test_random();
        int p_wr;
        bit wr, rd, clr;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                bus.af_thresh = 5'($urandom_range(0, 20));
                bus.ae_thresh = 5'($urandom_range(0, 20));
            end
            p_wr = (((i / 100) % 3) == 0) ? 85 : ((((i / 100) % 3) == 1) ? 50 : 15);
            wr  = ($urandom_range(0, 99) < p_wr);
            rd  = ($urandom_range(0, 99) < (100 - p_wr));
            clr = ($urandom_range(0, 19) == 0);
            step(wr, 4'($urandom), rd, clr);
            checks++; if (bus.fifo_counter !== 5'(q.size())) begin errors++; $display("FAIL rnd_count cyc=%0d actual=%0d expected=%0d", i, bus.fifo_counter, q.size()); end
            checks++; if (bus.buf_out !== exp_dout()) begin errors++; $display("FAIL rnd_dout cyc=%0d actual=%0d expected=%0d", i, bus.buf_out, exp_dout()); end
            checks++; if ({bus.buf_full, bus.buf_empty} !== {q.size() == DEPTH, q.size() == 0}) begin errors++; $display("FAIL rnd_fe cyc=%0d actual=%b%b cnt=%0d", i, bus.buf_full, bus.buf_empty, q.size()); end
            checks++; if ({bus.almost_full, bus.almost_empty} !== {exp_af(), exp_ae()}) begin errors++; $display("FAIL rnd_almost cyc=%0d actual=%b%b expected=%b%b", i, bus.almost_full, bus.almost_empty, exp_af(), exp_ae()); end
            checks++; if ({bus.overflow, bus.underflow} !== {m_ovf, m_unf}) begin errors++; $display("FAIL rnd_err cyc=%0d actual=%b%b expected=%b%b", i, bus.overflow, bus.underflow, m_ovf, m_unf); end
        end
        bus.af_thresh = 5'd2;
        bus.ae_thresh = 5'd2;
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] first;
        while (q.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 4'($urandom_range(1, 15)), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.fifo_counter !== 5'd7) begin errors++; $display("FAIL ar_pre_count actual=%0d expected=7", bus.fifo_counter); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.fifo_counter !== 5'd0) begin errors++; $display("FAIL ar_count actual=%0d expected=0", bus.fifo_counter); end
        checks++; if ({bus.buf_empty, bus.buf_full, bus.almost_empty} !== 3'b101) begin errors++; $display("FAIL ar_flags actual=%b expected=101", {bus.buf_empty, bus.buf_full, bus.almost_empty}); end
        checks++; if (bus.buf_out !== 4'd0) begin errors++; $display("FAIL ar_dout actual=%0d expected=0", bus.buf_out); end
        checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL ar_err actual=%b expected=00", {bus.overflow, bus.underflow}); end
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        first = 4'($urandom_range(1, 15));
        step(1'b1, first, 1'b0, 1'b0);
        step(1'b1, ~first, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.buf_out !== exp_dout()) begin errors++; $display("FAIL ar_post_dout actual=%0d expected=%0d", bus.buf_out, exp_dout()); end
        checks++; if (bus.fifo_counter !== 5'd1) begin errors++; $display("FAIL ar_post_count actual=%0d expected=1", bus.fifo_counter); end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

`ifdef FIFO_FWFT_EN
    task automatic test_fwft();
        step(1'b1, 4'd6, 1'b0, 1'b0);
        checks++; if (bus.buf_out !== 4'd6) begin errors++; $display("FAIL fwft_show actual=%0d expected=6", bus.buf_out); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.buf_out !== 4'd0) begin errors++; $display("FAIL fwft_empty actual=%0d expected=0", bus.buf_out); end
    endtask
`endif

    initial begin
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.err_clr   = 1'b0;
        bus.buf_in    = '0;
        bus.af_thresh = 5'd2;
        bus.ae_thresh = 5'd2;
        test_reset();
        test_ordering();
        test_fill_overflow();
        test_full_simul();
        test_empty_simul();
        test_random();
        test_async_reset();
`ifdef FIFO_FWFT_EN
        test_fwft();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
